cpu_oci_dct_packer: RTL

- Sequencing controller for the OCI data-capture-trace (DCT) accumulator of a Nios II core.
- Packs 2-bit DCT codes into the 30-bit dct_buffer and counts them in the 4-bit dct_count.
- Emits full or flushed words to the downstream trace FIFO over a valid/ready handshake.
- Handles end-of-test draining; exposes dct_buffer/dct_count/test_ending/test_has_ended to the OCI simulation test bench.

---
 rtl/cpu_oci_dct_packer.sv | 119 +++++++++++
 1 files changed

// File: rtl/cpu_oci_dct_packer.sv
// Packs 2-bit DCT trace codes into 30-bit words and hands full or flushed words to the trace FIFO.
// Also sequences end-of-test draining for the OCI simulation bench.
module cpu_oci_dct_packer #(
  parameter int unsigned CODE_W = 2,
  parameter int unsigned SLOTS  = 15,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            code_valid,
  input  logic [CODE_W-1:0]               code_in,
  input  logic                            flush_req,
  input  logic                            test_ending,
  input  logic                            overflow_clr,
  input  logic                            tw_ready,
  output logic                            tw_valid,
  output logic [CNT_W+CODE_W*SLOTS-1:0]   tw_data,
  output logic [CODE_W*SLOTS-1:0]         dct_buffer,
  output logic [CNT_W-1:0]                dct_count,
  output logic                            overflow,
  output logic                            test_has_ended
);

  localparam int unsigned     BUF_W = CODE_W * SLOTS;
  localparam int unsigned     WRD_W = CNT_W + BUF_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(SLOTS);

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_ENDED = 2'd2;

  logic [1:0]       state, state_n;
  logic             flush_pend, flush_pend_n;
  logic [BUF_W-1:0] buf_n, buf_pa;
  logic [CNT_W-1:0] cnt_n, cnt_pa;
  logic             tw_valid_n;
  logic [WRD_W-1:0] tw_data_n;
  logic             overflow_n;
  logic             ended_n;
  logic             slot_free, live, accept, drop, flush_evt, load;

  // Next-state, accumulator and output-slot logic
  always_comb begin
    state_n      = state;
    flush_pend_n = 1'b0;
    buf_n        = dct_buffer;
    cnt_n        = dct_count;
    tw_valid_n   = tw_valid;
    tw_data_n    = tw_data;
    overflow_n   = overflow;
    ended_n      = test_has_ended;
    flush_evt    = 1'b0;

    slot_free = !tw_valid || tw_ready;
    live      = (state != ST_ENDED);
    accept    = live && code_valid && (dct_count != FULL);
    drop      = live && code_valid && (dct_count == FULL) && !slot_free;
    buf_pa    = accept ? {dct_buffer[BUF_W-CODE_W-1:0], code_in} : dct_buffer;
    cnt_pa    = accept ? dct_count + CNT_W'(1) : dct_count;

    // DRAIN keeps flushing so codes arriving late still leave before ENDED
    unique case (state)
      ST_ACCUM: flush_evt = flush_req || test_ending || flush_pend;
      ST_DRAIN: flush_evt = 1'b1;
      default:  flush_evt = 1'b0;
    endcase

    load = slot_free && ((cnt_pa == FULL) || (flush_evt && (cnt_pa != '0)));

    if (load) begin
      tw_valid_n = 1'b1;
      tw_data_n  = {cnt_pa, buf_pa};
      buf_n      = '0;
      cnt_n      = '0;
    end else begin
      if (tw_valid && tw_ready) tw_valid_n = 1'b0;
      buf_n = buf_pa;
      cnt_n = cnt_pa;
    end

    flush_pend_n = flush_evt && (cnt_pa != '0) && !load;
    overflow_n   = drop || (overflow && !overflow_clr);

    unique case (state)
      ST_ACCUM: if (test_ending) state_n = ST_DRAIN;
      ST_DRAIN: begin
        if ((cnt_pa == '0) && !flush_pend && slot_free) begin
          state_n = ST_ENDED;
          ended_n = 1'b1;
        end
      end
      default: state_n = state;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_ACCUM;
      flush_pend     <= 1'b0;
      dct_buffer     <= '0;
      dct_count      <= '0;
      tw_valid       <= 1'b0;
      tw_data        <= '0;
      overflow       <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      state          <= state_n;
      flush_pend     <= flush_pend_n;
      dct_buffer     <= buf_n;
      dct_count      <= cnt_n;
      tw_valid       <= tw_valid_n;
      tw_data        <= tw_data_n;
      overflow       <= overflow_n;
      test_has_ended <= ended_n;
    end
  end

endmodule
